riscv_rf_wb_arbiter: RTL

//  Writeback arbiter between the result producers (ALU, mult/div, LSU, FPU) and the two register-file write ports (A, B).

---
 rtl/riscv_rf_wb_arbiter_if.sv | 45 ++++
 rtl/riscv_rf_wb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_rf_wb_arbiter_if.sv
// Writeback arbiter bus: producer enqueue side plus the two register-file write ports.
// pending_o is present only when RF_WB_SCOREBOARD_EN is defined.
interface riscv_rf_wb_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_SRC-1:0]            src_valid_i;
    logic [NUM_SRC-1:0]            src_ready_o;
    logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr_i;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i;
    logic                          flush_i;
    logic [ADDR_WIDTH-1:0]         waddr_a_o;
    logic [DATA_WIDTH-1:0]         wdata_a_o;
    logic                          we_a_o;
    logic [ADDR_WIDTH-1:0]         waddr_b_o;
    logic [DATA_WIDTH-1:0]         wdata_b_o;
    logic                          we_b_o;
    logic                          busy_o;
`ifdef RF_WB_SCOREBOARD_EN
    logic [2**ADDR_WIDTH-1:0]      pending_o;

    modport slave (
        input  src_valid_i, src_addr_i, src_data_i, flush_i,
        output src_ready_o, waddr_a_o, wdata_a_o, we_a_o,
        output waddr_b_o, wdata_b_o, we_b_o, busy_o, pending_o
    );
    modport master (
        output src_valid_i, src_addr_i, src_data_i, flush_i,
        input  src_ready_o, waddr_a_o, wdata_a_o, we_a_o,
        input  waddr_b_o, wdata_b_o, we_b_o, busy_o, pending_o
    );
`else
    modport slave (
        input  src_valid_i, src_addr_i, src_data_i, flush_i,
        output src_ready_o, waddr_a_o, wdata_a_o, we_a_o,
        output waddr_b_o, wdata_b_o, we_b_o, busy_o
    );
    modport master (
        output src_valid_i, src_addr_i, src_data_i, flush_i,
        input  src_ready_o, waddr_a_o, wdata_a_o, we_a_o,
        input  waddr_b_o, wdata_b_o, we_b_o, busy_o
    );
`endif
endinterface

// File: rtl/riscv_rf_wb_arbiter.sv
// Per-source result FIFOs feeding two register-file write ports, dual-issue round-robin.
// Optional RF_WB_SCOREBOARD_EN adds pending_o, a map of registers with writes in flight.
module riscv_rf_wb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    riscv_rf_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

    logic [CNT_W-1:0]      count_q [NUM_SRC];
    logic [CNT_W-1:0]      count_d [NUM_SRC];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_SRC];
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
    logic                  we_a_q, we_a_d, we_b_q, we_b_d;

    logic [NUM_SRC-1:0]    src_ready, push, pop, not_empty, cand, zero_head;
    logic [ADDR_WIDTH-1:0] head_addr [NUM_SRC];
    logic [DATA_WIDTH-1:0] head_data [NUM_SRC];
    logic                  g1_vld, g2_vld, g2_issue, issue_a, issue_b;
    logic [SRC_W-1:0]      g1_idx, g2_idx;

`ifdef RF_WB_SCOREBOARD_EN
    logic                  ent_vld  [NUM_SRC][FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] ent_addr [NUM_SRC][FIFO_DEPTH];
    logic [2**ADDR_WIDTH-1:0] pending;
`endif

    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] s);
        return (s == SRC_W'(NUM_SRC - 1)) ? '0 : s + SRC_W'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem_q[wr_ptr_q[gi]] <= {bus.src_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH],
                                            bus.src_data_i[gi*DATA_WIDTH +: DATA_WIDTH]};
                end
            end

            assign not_empty[gi] = (count_q[gi] != '0);
            assign src_ready[gi] = (count_q[gi] < CNT_W'(FIFO_DEPTH));
            assign push[gi]      = bus.src_valid_i[gi] & src_ready[gi] & ~bus.flush_i;
            assign head_addr[gi] = mem_q[rd_ptr_q[gi]][ENT_W-1 -: ADDR_WIDTH];
            assign head_data[gi] = mem_q[rd_ptr_q[gi]][DATA_WIDTH-1:0];
            // x0 heads are discarded in place and never compete for a port
            assign zero_head[gi] = not_empty[gi] && (head_addr[gi] == '0);
            assign cand[gi]      = not_empty[gi] && (head_addr[gi] != '0);
            assign pop[gi]       = zero_head[gi]
                                 | (issue_a && (g1_idx == SRC_W'(gi)))
                                 | (issue_b && (g2_idx == SRC_W'(gi)));

`ifdef RF_WB_SCOREBOARD_EN
            genvar ge;
            for (ge = 0; ge < FIFO_DEPTH; ge++) begin : g_ent
                logic [PTR_W-1:0] off;
                assign off               = PTR_W'(ge) - rd_ptr_q[gi];
                assign ent_vld[gi][ge]   = ({1'b0, off} < count_q[gi]);
                assign ent_addr[gi][ge]  = mem_q[ge][ENT_W-1 -: ADDR_WIDTH];
            end
`endif
        end
    endgenerate

    always_comb begin
        int j;
        j      = 0;
        g1_vld = 1'b0;
        g2_vld = 1'b0;
        g1_idx = '0;
        g2_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (cand[j]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = SRC_W'(j);
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_idx = SRC_W'(j);
                end
            end
        end
    end

    // A same-address second grant waits a cycle so A and B never collide
    assign g2_issue = g2_vld && (head_addr[g2_idx] != head_addr[g1_idx]);
    assign issue_a  = g1_vld & ~bus.flush_i;
    assign issue_b  = g2_issue & ~bus.flush_i;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            count_d[s]  = count_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            wr_ptr_d[s] = wr_ptr_q[s];
            if (bus.flush_i) begin
                count_d[s]  = '0;
                rd_ptr_d[s] = '0;
                wr_ptr_d[s] = '0;
            end else begin
                if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
                if (pop[s])  rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
                count_d[s] = count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (issue_b)      rr_ptr_d = rr_next(g2_idx);
        else if (issue_a) rr_ptr_d = rr_next(g1_idx);

        we_a_d    = issue_a;
        we_b_d    = issue_b;
        waddr_a_d = issue_a ? head_addr[g1_idx] : waddr_a_q;
        wdata_a_d = issue_a ? head_data[g1_idx] : wdata_a_q;
        waddr_b_d = issue_b ? head_addr[g2_idx] : waddr_b_q;
        wdata_b_d = issue_b ? head_data[g2_idx] : wdata_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count_q[s]  <= '0;
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
            end
            rr_ptr_q  <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count_q[s]  <= count_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                wr_ptr_q[s] <= wr_ptr_d[s];
            end
            rr_ptr_q  <= rr_ptr_d;
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
        end
    end

    assign bus.src_ready_o = src_ready;
    assign bus.we_a_o      = we_a_q;
    assign bus.waddr_a_o   = waddr_a_q;
    assign bus.wdata_a_o   = wdata_a_q;
    assign bus.we_b_o      = we_b_q;
    assign bus.waddr_b_o   = waddr_b_q;
    assign bus.wdata_b_o   = wdata_b_q;
    assign bus.busy_o      = (|not_empty) | we_a_q | we_b_q;

`ifdef RF_WB_SCOREBOARD_EN
    always_comb begin
        pending = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (ent_vld[s][e]) pending[ent_addr[s][e]] = 1'b1;
            end
        end
        if (we_a_q) pending[waddr_a_q] = 1'b1;
        if (we_b_q) pending[waddr_b_q] = 1'b1;
        pending[0] = 1'b0;
    end

    assign bus.pending_o = pending;
`endif
endmodule
